// File: rtl/bp_pkg.sv
// Shared branch-predictor types: default widths plus the per-branch metadata and outcome records.
package bp_pkg;

  localparam int BP_XLEN        = 32;
  localparam int BP_PHT_ADDRESS = 9;
  localparam int BP_GHR_W       = 9;

  typedef struct packed {
    logic [BP_XLEN-1:0]        pc;
    logic [BP_PHT_ADDRESS-1:0] pht_index;
    logic [BP_GHR_W-1:0]       ghr;
    logic                      pred_taken;
    logic [BP_XLEN-1:0]        pred_target;
  } bp_meta_t;

  typedef struct packed {
    logic               taken;
    logic [BP_XLEN-1:0] target;
    logic               is_ret;
  } bp_outcome_t;

endpackage

// File: rtl/branch_update_unit_if.sv
// Signal bundle between the predict/execute stages (master) and the branch update unit (slave).
interface branch_update_unit_if #(
  parameter int PHT_ADDRESS = bp_pkg::BP_PHT_ADDRESS,
  parameter int XLEN        = bp_pkg::BP_XLEN,
  parameter int DEPTH       = 8,
  parameter int GHR_W       = bp_pkg::BP_GHR_W
);
  localparam int TAG_W = $clog2(DEPTH);

  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [TAG_W-1:0]       alloc_tag;
  logic [XLEN-1:0]        alloc_pc;
  logic [PHT_ADDRESS-1:0] alloc_pht_index;
  logic [GHR_W-1:0]       alloc_ghr;
  logic                   alloc_pred_taken;
  logic [XLEN-1:0]        alloc_pred_target;
  logic                   res_valid;
  logic [TAG_W-1:0]       res_tag;
  logic                   res_taken;
  logic [XLEN-1:0]        res_target;
  logic                   res_is_ret;
  logic                   update_pht;
  logic                   update_btb;
  logic                   actual_taken;
  logic [PHT_ADDRESS-1:0] rb_pht_index;
  logic [XLEN-1:0]        ex_pc;
  logic [XLEN-1:0]        actual_target_address;
  logic                   ex_is_ret;
  logic                   mispredict;
  logic [XLEN-1:0]        redirect_pc;
  logic [GHR_W-1:0]       restore_ghr;
  logic [TAG_W:0]         count;

  modport master (
    output alloc_valid, alloc_pc, alloc_pht_index, alloc_ghr, alloc_pred_taken, alloc_pred_target,
    output res_valid, res_tag, res_taken, res_target, res_is_ret,
    input  alloc_ready, alloc_tag, update_pht, update_btb, actual_taken, rb_pht_index, ex_pc,
    input  actual_target_address, ex_is_ret, mispredict, redirect_pc, restore_ghr, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pht_index, alloc_ghr, alloc_pred_taken, alloc_pred_target,
    input  res_valid, res_tag, res_taken, res_target, res_is_ret,
    output alloc_ready, alloc_tag, update_pht, update_btb, actual_taken, rb_pht_index, ex_pc,
    output actual_target_address, ex_is_ret, mispredict, redirect_pc, restore_ghr, count
  );

endinterface

// File: rtl/buu_meta_buffer.sv
// Prediction metadata storage: one write port at allocation, asynchronous reads for resolve and retire.
module buu_meta_buffer
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [TAG_W-1:0] waddr,
  input  bp_meta_t         wdata,
  input  logic [TAG_W-1:0] res_addr,
  output bp_meta_t         res_data,
  input  logic [TAG_W-1:0] head_addr,
  output bp_meta_t         head_data
);

  bp_meta_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign res_data  = mem[res_addr];
  assign head_data = mem[head_addr];

endmodule

// File: rtl/branch_update_unit.sv
// In-order retire buffer for predicted branches: drives PHT/BTB updates and mispredict redirects.
// Define BUU_STATS_EN to add saturating retired/mispredict counters.
module branch_update_unit
  import bp_pkg::*;
#(
  parameter int PHT_ADDRESS = BP_PHT_ADDRESS,
  parameter int XLEN        = BP_XLEN,
  parameter int DEPTH       = 8,
  parameter int GHR_W       = BP_GHR_W
) (
  input  logic CLK,
  input  logic reset,
  branch_update_unit_if.slave bus
`ifdef BUU_STATS_EN
  ,
  output logic [31:0] stat_retired,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int TAG_W = $clog2(DEPTH);

  logic [TAG_W-1:0] head, tail, head_nxt, tail_nxt, span, res_age, ent_age;
  logic [TAG_W:0]   cnt, cnt_nxt;
  logic [DEPTH-1:0] valid, resolved, valid_nxt, resolved_nxt;
  bp_outcome_t      outcome [DEPTH];
  bp_meta_t         alloc_meta, res_meta, head_meta;
  logic             full, alloc_fire, res_ok, mis, retire_fire, unused_meta;

  logic                   update_pht_r, update_btb_r, actual_taken_r, ex_is_ret_r, mispredict_r;
  logic [PHT_ADDRESS-1:0] rb_pht_index_r;
  logic [XLEN-1:0]        ex_pc_r, actual_target_r, redirect_pc_r;
  logic [GHR_W-1:0]       restore_ghr_r;

  assign full        = (cnt == (TAG_W+1)'(DEPTH));
  assign alloc_fire  = bus.alloc_valid & ~full;
  assign retire_fire = valid[head] & resolved[head];
  assign res_ok      = bus.res_valid & valid[bus.res_tag] & ~resolved[bus.res_tag];
  assign mis         = res_ok & ((bus.res_taken != res_meta.pred_taken) |
                       (bus.res_taken & (bus.res_target != XLEN'(res_meta.pred_target))));

  assign alloc_meta = '{pc:          BP_XLEN'(bus.alloc_pc),
                        pht_index:   BP_PHT_ADDRESS'(bus.alloc_pht_index),
                        ghr:         BP_GHR_W'(bus.alloc_ghr),
                        pred_taken:  bus.alloc_pred_taken,
                        pred_target: BP_XLEN'(bus.alloc_pred_target)};

  assign unused_meta = ^{res_meta.pht_index, head_meta.ghr, head_meta.pred_taken, head_meta.pred_target};

  buu_meta_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_meta (
    .CLK       (CLK),
    .we        (alloc_fire),
    .waddr     (tail),
    .wdata     (alloc_meta),
    .res_addr  (bus.res_tag),
    .res_data  (res_meta),
    .head_addr (head),
    .head_data (head_meta)
  );

  // Entries are aged relative to head, so "younger than res_tag" is simply a larger age.
  always_comb begin
    valid_nxt    = valid;
    resolved_nxt = resolved;
    head_nxt     = head;
    tail_nxt     = tail;
    cnt_nxt      = cnt;
    span         = '0;
    ent_age      = '0;
    res_age      = bus.res_tag - head;
    if (retire_fire) begin
      valid_nxt[head] = 1'b0;
      head_nxt        = head + 1'b1;
    end
    if (res_ok) resolved_nxt[bus.res_tag] = 1'b1;
    if (mis) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_age = TAG_W'(i) - head;
        if (ent_age > res_age) valid_nxt[i] = 1'b0;
      end
      tail_nxt = bus.res_tag + 1'b1;
      span     = tail_nxt - head_nxt;
      cnt_nxt  = (span == '0 && valid_nxt[head_nxt]) ? (TAG_W+1)'(DEPTH) : {1'b0, span};
    end else begin
      if (alloc_fire) begin
        valid_nxt[tail]    = 1'b1;
        resolved_nxt[tail] = 1'b0;
        tail_nxt           = tail + 1'b1;
      end
      cnt_nxt = cnt + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_fire);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      valid    <= '0;
      resolved <= '0;
    end else begin
      head     <= head_nxt;
      tail     <= tail_nxt;
      cnt      <= cnt_nxt;
      valid    <= valid_nxt;
      resolved <= resolved_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (res_ok) outcome[bus.res_tag] <= '{taken: bus.res_taken, target: BP_XLEN'(bus.res_target),
                                          is_ret: bus.res_is_ret};
  end

  // Update fields hold their last retired values; only the pulses return to zero.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      update_pht_r    <= 1'b0;
      update_btb_r    <= 1'b0;
      actual_taken_r  <= 1'b0;
      ex_is_ret_r     <= 1'b0;
      mispredict_r    <= 1'b0;
      rb_pht_index_r  <= '0;
      ex_pc_r         <= '0;
      actual_target_r <= '0;
      redirect_pc_r   <= '0;
      restore_ghr_r   <= '0;
    end else begin
      update_pht_r <= retire_fire;
      update_btb_r <= retire_fire & outcome[head].taken;
      mispredict_r <= mis;
      if (retire_fire) begin
        actual_taken_r  <= outcome[head].taken;
        ex_is_ret_r     <= outcome[head].is_ret;
        rb_pht_index_r  <= PHT_ADDRESS'(head_meta.pht_index);
        ex_pc_r         <= XLEN'(head_meta.pc);
        actual_target_r <= XLEN'(outcome[head].target);
      end
      if (mis) begin
        redirect_pc_r <= bus.res_taken ? bus.res_target : XLEN'(res_meta.pc + BP_XLEN'(4));
        restore_ghr_r <= GHR_W'({res_meta.ghr[BP_GHR_W-2:0], bus.res_taken});
      end
    end
  end

`ifdef BUU_STATS_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stat_retired     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (retire_fire && stat_retired != '1) stat_retired <= stat_retired + 32'd1;
      if (mis && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  assign bus.alloc_ready           = ~full;
  assign bus.alloc_tag             = tail;
  assign bus.count                 = cnt;
  assign bus.update_pht            = update_pht_r;
  assign bus.update_btb            = update_btb_r;
  assign bus.actual_taken          = actual_taken_r;
  assign bus.rb_pht_index          = rb_pht_index_r;
  assign bus.ex_pc                 = ex_pc_r;
  assign bus.actual_target_address = actual_target_r;
  assign bus.ex_is_ret             = ex_is_ret_r;
  assign bus.mispredict            = mispredict_r;
  assign bus.redirect_pc           = redirect_pc_r;
  assign bus.restore_ghr           = restore_ghr_r;

endmodule

// File: tb/tb_branch_update_unit.sv
// Testbench for branch_update_unit: directed scenarios plus random traffic against a queue-based model.
module tb_branch_update_unit;
  localparam int PHT_ADDRESS = 9;
  localparam int XLEN        = 32;
  localparam int DEPTH       = 8;
  localparam int GHR_W       = 9;
  localparam int TAG_W       = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_update_unit_if #(.PHT_ADDRESS(PHT_ADDRESS), .XLEN(XLEN), .DEPTH(DEPTH), .GHR_W(GHR_W)) bus ();
`ifdef BUU_STATS_EN
  logic [31:0] stat_retired, stat_mispredicts;
`endif

  branch_update_unit #(.PHT_ADDRESS(PHT_ADDRESS), .XLEN(XLEN), .DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef BUU_STATS_EN
    ,
    .stat_retired     (stat_retired),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Reference model: in-flight branches oldest-first, each carrying its tag and outcome.
  typedef struct {
    int                     tag;
    logic [XLEN-1:0]        pc;
    logic [PHT_ADDRESS-1:0] pht;
    logic [GHR_W-1:0]       ghr;
    logic                   pt;
    logic [XLEN-1:0]        ptgt;
    bit                     done;
    logic                   taken;
    logic [XLEN-1:0]        tgt;
    logic                   ret;
  } br_t;

  br_t inflight[$];
  int  next_tag;
  int  checks = 0;
  int  failures = 0;

  logic                   e_pht, e_btb, e_taken, e_ret, e_mis;
  logic [PHT_ADDRESS-1:0] e_idx;
  logic [XLEN-1:0]        e_pc, e_tgt, e_rpc;
  logic [GHR_W-1:0]       e_rghr;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    inflight.delete();
    next_tag = 0;
    {e_pht, e_btb, e_taken, e_ret, e_mis} = '0;
    e_idx = '0; e_pc = '0; e_tgt = '0; e_rpc = '0; e_rghr = '0;
  endtask

  // One clock cycle: drive at negedge, check pre-edge status, advance the model, check after the edge.
  task automatic applyStimulus(input bit av, input logic [XLEN-1:0] pc, input logic [PHT_ADDRESS-1:0] pht,
                               input logic [GHR_W-1:0] ghr, input bit pt, input logic [XLEN-1:0] ptgt,
                               input bit rv, input int rtag, input bit rtaken, input logic [XLEN-1:0] rtgt,
                               input bit rret);
    int  idx;
    bit  ready, retire, mis;
    br_t nb;
    bus.alloc_valid = av; bus.alloc_pc = pc; bus.alloc_pht_index = pht; bus.alloc_ghr = ghr;
    bus.alloc_pred_taken = pt; bus.alloc_pred_target = ptgt;
    bus.res_valid = rv; bus.res_tag = TAG_W'(rtag); bus.res_taken = rtaken;
    bus.res_target = rtgt; bus.res_is_ret = rret;
    #1;
    ready = (inflight.size() < DEPTH);
    checkOutput("alloc_ready", 64'(bus.alloc_ready), 64'(ready));
    checkOutput("alloc_tag", 64'(bus.alloc_tag), 64'(next_tag));
    checkOutput("count", 64'(bus.count), 64'(inflight.size()));

    retire = (inflight.size() > 0) && inflight[0].done;
    idx = -1;
    if (rv) foreach (inflight[i]) if (inflight[i].tag == rtag && !inflight[i].done) idx = i;
    mis = 1'b0;
    if (idx >= 0) begin
      mis = (rtaken != inflight[idx].pt) || (rtaken && rtgt != inflight[idx].ptgt);
      if (mis) begin
        e_rpc  = rtaken ? rtgt : inflight[idx].pc + 32'd4;
        e_rghr = {inflight[idx].ghr[GHR_W-2:0], rtaken};
      end
      inflight[idx].done  = 1'b1;
      inflight[idx].taken = rtaken;
      inflight[idx].tgt   = rtgt;
      inflight[idx].ret   = rret;
    end
    e_mis = mis;
    e_pht = retire;
    e_btb = retire && inflight[0].taken;
    if (retire) begin
      e_taken = inflight[0].taken; e_ret = inflight[0].ret; e_idx = inflight[0].pht;
      e_pc = inflight[0].pc; e_tgt = inflight[0].tgt;
    end
    if (mis) begin
      while (inflight.size() > idx + 1) void'(inflight.pop_back());
      next_tag = (rtag + 1) % DEPTH;
    end else if (av && ready) begin
      nb = '{tag: next_tag, pc: pc, pht: pht, ghr: ghr, pt: pt, ptgt: ptgt,
             done: 1'b0, taken: 1'b0, tgt: '0, ret: 1'b0};
      inflight.push_back(nb);
      next_tag = (next_tag + 1) % DEPTH;
    end
    if (retire) void'(inflight.pop_front());

    @(posedge clk); #1;
    checkOutput("update_pht", 64'(bus.update_pht), 64'(e_pht));
    checkOutput("update_btb", 64'(bus.update_btb), 64'(e_btb));
    checkOutput("mispredict", 64'(bus.mispredict), 64'(e_mis));
    checkOutput("actual_taken", 64'(bus.actual_taken), 64'(e_taken));
    checkOutput("rb_pht_index", 64'(bus.rb_pht_index), 64'(e_idx));
    checkOutput("ex_pc", 64'(bus.ex_pc), 64'(e_pc));
    checkOutput("actual_target", 64'(bus.actual_target_address), 64'(e_tgt));
    checkOutput("ex_is_ret", 64'(bus.ex_is_ret), 64'(e_ret));
    checkOutput("redirect_pc", 64'(bus.redirect_pc), 64'(e_rpc));
    checkOutput("restore_ghr", 64'(bus.restore_ghr), 64'(e_rghr));
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, '0, '0, '0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  task automatic doAlloc(input logic [XLEN-1:0] pc, input logic [PHT_ADDRESS-1:0] pht,
                         input logic [GHR_W-1:0] ghr, input bit pt, input logic [XLEN-1:0] ptgt);
    applyStimulus(1, pc, pht, ghr, pt, ptgt, 0, 0, 0, '0, 0);
  endtask

  task automatic doResolve(input int tag, input bit taken, input logic [XLEN-1:0] tgt, input bit ret);
    applyStimulus(0, '0, '0, '0, 0, '0, 1, tag, taken, tgt, ret);
  endtask

  task automatic drain();
    int guard = 0;
    while (inflight.size() > 0 && guard < 40) begin
      int k = -1;
      foreach (inflight[i]) if (!inflight[i].done && k < 0) k = i;
      if (k >= 0) doResolve(inflight[k].tag, inflight[k].pt, inflight[k].ptgt, 0);
      else idleCycle();
      guard++;
    end
    idleCycle();
    checkOutput("drain_count", 64'(bus.count), 64'(0));
  endtask

  task automatic randomPhase(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      int open[$];
      int k, rtag;
      bit av, rv, rt, pt;
      logic [XLEN-1:0] pc, ptgt, rtgt;
      open.delete();
      av   = ($urandom_range(0, 99) < 55);
      pt   = 1'($urandom_range(0, 1));
      pc   = $urandom & 32'hFFFF_FFFC;
      ptgt = $urandom & 32'hFFFF_FFFC;
      foreach (inflight[i]) if (!inflight[i].done) open.push_back(i);
      if (open.size() > 0 && $urandom_range(0, 99) < 70) begin
        k    = open[$urandom_range(0, open.size() - 1)];
        rv   = 1'b1;
        rtag = inflight[k].tag;
        if ($urandom_range(0, 99) < 75) begin
          rt   = inflight[k].pt;
          rtgt = inflight[k].pt ? inflight[k].ptgt : inflight[k].pc + 32'd4;
        end else begin
          rt   = 1'($urandom_range(0, 1));
          rtgt = $urandom & 32'hFFFF_FFFC;
        end
      end else begin
        rv   = 1'($urandom_range(0, 1));
        rtag = $urandom_range(0, DEPTH - 1);
        rt   = 1'($urandom_range(0, 1));
        rtgt = $urandom & 32'hFFFF_FFFC;
      end
      applyStimulus(av, pc, 9'($urandom), 9'($urandom), pt, ptgt, rv, rtag, rt, rtgt,
                    1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, t;
    bus.alloc_valid = 0; bus.alloc_pc = '0; bus.alloc_pht_index = '0; bus.alloc_ghr = '0;
    bus.alloc_pred_taken = 0; bus.alloc_pred_target = '0; bus.res_valid = 0; bus.res_tag = '0;
    bus.res_taken = 0; bus.res_target = '0; bus.res_is_ret = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_count", 64'(bus.count), 64'(0));
    checkOutput("rst_tag", 64'(bus.alloc_tag), 64'(0));
    checkOutput("rst_upd_pht", 64'(bus.update_pht), 64'(0));
    checkOutput("rst_mispredict", 64'(bus.mispredict), 64'(0));
    checkOutput("rst_redirect", 64'(bus.redirect_pc), 64'(0));
    rst_n = 1'b1;
    modelReset();

    // Correctly predicted not-taken branch reaches the update port two cycles after resolution.
    doAlloc(32'h100, 9'h011, 9'h055, 0, 32'h104);
    doResolve(0, 0, 32'h104, 0);
    idleCycle();
    checkOutput("t1_upd_pht", 64'(bus.update_pht), 64'(1));
    checkOutput("t1_upd_btb", 64'(bus.update_btb), 64'(0));
    checkOutput("t1_ex_pc", 64'(bus.ex_pc), 64'(32'h100));

    // Taken with the wrong target: redirect and GHR repair, then a BTB update.
    doAlloc(32'h200, 9'h022, 9'h0A5, 1, 32'h240);
    doResolve(1, 1, 32'h280, 0);
    checkOutput("t2_mispredict", 64'(bus.mispredict), 64'(1));
    checkOutput("t2_redirect", 64'(bus.redirect_pc), 64'(32'h280));
    checkOutput("t2_restore_ghr", 64'(bus.restore_ghr), 64'(9'h14B));
    idleCycle();
    checkOutput("t2_upd_btb", 64'(bus.update_btb), 64'(1));
    checkOutput("t2_target", 64'(bus.actual_target_address), 64'(32'h280));

    // Out-of-order resolution, in-order retirement on consecutive cycles.
    base = next_tag;
    for (int i = 0; i < 4; i++) doAlloc(32'h300 + 32'(i * 16), 9'(i), 9'h0, 0, '0);
    doResolve((base + 2) % DEPTH, 0, '0, 0);
    doResolve((base + 1) % DEPTH, 0, '0, 0);
    doResolve((base + 3) % DEPTH, 0, '0, 0);
    doResolve(base, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("t3_upd_pht", 64'(bus.update_pht), 64'(1));
      checkOutput("t3_order", 64'(bus.ex_pc), 64'(32'h300 + 32'(i * 16)));
    end

    // Mispredict on the second of four squashes the two younger entries.
    base = next_tag;
    for (int i = 0; i < 4; i++) doAlloc(32'h400 + 32'(i * 4), 9'h0, 9'h0, 0, '0);
    doResolve((base + 1) % DEPTH, 1, 32'h500, 0);
    checkOutput("t4_count", 64'(bus.count), 64'(2));
    checkOutput("t4_next_tag", 64'(bus.alloc_tag), 64'((base + 2) % DEPTH));
    doResolve((base + 3) % DEPTH, 0, '0, 0);
    checkOutput("t4_late_ignored", 64'(bus.mispredict), 64'(0));
    drain();

    // Fill to full, retire one while an allocation is held off, then wrap the tail.
    t = next_tag;
    for (int i = 0; i < DEPTH; i++) doAlloc(32'h600 + 32'(i * 4), 9'(i), 9'h1, 0, '0);
    checkOutput("t5_full_ready", 64'(bus.alloc_ready), 64'(0));
    doResolve(t, 0, '0, 0);
    applyStimulus(1, 32'h6F0, '0, '0, 0, '0, 0, 0, 0, '0, 0);
    checkOutput("t5_ready_again", 64'(bus.alloc_ready), 64'(1));
    checkOutput("t5_wrap_tag", 64'(bus.alloc_tag), 64'(t));
    doAlloc(32'h700, 9'h3, 9'h2, 1, 32'h740);
    drain();

    // Reset with branches in flight discards everything and suppresses pulses.
    for (int i = 0; i < 5; i++) doAlloc(32'h800 + 32'(i * 4), 9'h5, 9'h3, 0, '0);
    doResolve(next_tag - 5 < 0 ? next_tag + DEPTH - 5 : next_tag - 5, 0, '0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_count", 64'(bus.count), 64'(0));
    checkOutput("t6_ex_pc", 64'(bus.ex_pc), 64'(0));
    @(posedge clk); #1;
    checkOutput("t6_no_pulse", 64'(bus.update_pht), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    idleCycle();
    checkOutput("t6_tag0", 64'(bus.alloc_tag), 64'(0));
    doAlloc(32'h900, 9'h7, 9'h4, 0, '0);
    drain();

    randomPhase(600);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_update_unit.md
Name: branch_update_unit

Overview:
Resolution-side counterpart of the predict/decode stage. It holds per-branch prediction metadata from allocation until execute resolves the branch. It then retires branches in program order and drives the PHT/BTB update interface, including actual_taken, rb_pht_index, ex_pc, actual_target_address and ex_is_ret. On a misprediction it also drives the fetch redirect and the GHR restore.

Parameters:
PHT_ADDRESS, 9, PHT index width; must match the predictor.
XLEN, 32, address width.
DEPTH, 8, in-flight branch entries; power of 2, at least 2.
GHR_W, 9, global history width.
TAG_W (localparam), $clog2(DEPTH), branch tag width.

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
alloc_valid  in  1  predict stage requests an entry for a predicted branch
alloc_ready  out  1  entry available (not full)
alloc_tag  out  TAG_W  tag assigned on the current handshake (tail pointer)
alloc_pc  in  XLEN  branch PC
alloc_pht_index  in  PHT_ADDRESS  PHT index used at prediction
alloc_ghr  in  GHR_W  GHR snapshot at prediction
alloc_pred_taken  in  1  predicted direction
alloc_pred_target  in  XLEN  predicted target
res_valid  in  1  execute resolves a branch
res_tag  in  TAG_W  tag being resolved
res_taken  in  1  actual direction
res_target  in  XLEN  actual target
res_is_ret  in  1  branch is a return
update_pht  out  1  one-cycle PHT update pulse
update_btb  out  1  one-cycle BTB update pulse
actual_taken  out  1  retired direction
rb_pht_index  out  PHT_ADDRESS  retired PHT index
ex_pc  out  XLEN  retired branch PC
actual_target_address  out  XLEN  retired actual target
ex_is_ret  out  1  retired branch is a return
mispredict  out  1  one-cycle flush/redirect pulse
redirect_pc  out  XLEN  correct fetch PC
restore_ghr  out  GHR_W  corrected GHR
count  out  TAG_W+1  occupied entries

Behaviour:
- Reset (reset=0, asynchronous): head, tail and count are 0; all entry valid/resolved bits are 0. Every registered output is 0. alloc_ready is 1 once reset is released.
- Circular buffer: head and tail are TAG_W bits and wrap modulo DEPTH. full is count==DEPTH; empty is count==0.
- alloc_ready is !full, computed from registered state. A handshake (alloc_valid & alloc_ready) writes the entry at tail, sets valid=1 and resolved=0, and increments tail.
- Resolution, out of order:
  - If res_valid and entry[res_tag] is valid and unresolved, store the outcome and set resolved=1.
  - A resolution to an invalid or already-resolved tag is ignored.
- Mispredict condition: (res_taken != pred_taken) or (res_taken and res_target != pred_target).
- Mispredict response, registered, one cycle after res_valid:
  - mispredict=1.
  - redirect_pc = res_taken ? res_target : pc+4.
  - restore_ghr = {ghr[GHR_W-2:0], res_taken}.
- Mispredict squash, applied in the same edge as the resolution:
  - Entries strictly younger than res_tag are squashed: valid cleared, tail = res_tag+1.
  - count is recomputed as (tail - head), treating equal pointers with the head entry valid as full.
  - An allocation in the same cycle as a mispredicting resolution is dropped. The requester sees the handshake, but the entry is squashed.
- Retire, in order, at most one per cycle:
  - When entry[head] is valid and resolved, the next cycle presents that entry's update fields on the update outputs.
  - update_pht=1 for every retired branch.
  - update_btb=1 only if the retired branch was taken.
  - The entry is invalidated and head is incremented.
- Update outputs are registered and hold their last values. update_pht, update_btb and mispredict are single-cycle pulses.
- Simultaneous events: allocate, resolve and retire can all occur in one cycle.
  - count = count + alloc - retire.
  - When full, a same-cycle retire does not enable an allocation.
- A branch resolved and retired on the same head entry in one cycle is not allowed. Retire uses only the registered resolved bit, so the minimum resolve-to-update latency is 2 cycles.
- Asserting reset mid-operation discards all entries immediately. No update or mispredict pulse is produced afterwards.

Optional Feature:
- Macro: BUU_STATS_EN.
- Defined: 32-bit output ports stat_retired and stat_mispredicts are added.
  - stat_retired increments on each update_pht.
  - stat_mispredicts increments on each mispredict.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package bp_pkg:
  - GHR_W and the PHT_ADDRESS default.
  - typedef struct bp_meta_t {pc, pht_index, ghr, pred_taken, pred_target}.
  - typedef struct bp_outcome_t {taken, target, is_ret}.
- Sub-module buu_meta_buffer: DEPTH x bp_meta_t storage with one write port (alloc) and two read ports (res_tag, head).
- Valid/resolved bits, pointers and control logic stay in the top module.

Test Plan:
- Allocate pc=0x100 not-taken; resolve not-taken; it is head -> 2 cycles later update_pht=1, update_btb=0, mispredict=0.
- Allocate 0x200 predicted taken to 0x240; resolve taken to 0x280 -> next cycle mispredict=1, redirect_pc=0x280, restore_ghr={ghr[7:0],1}; the later update has update_btb=1 and actual_target_address=0x280.
- Allocate tags 0..3; resolve 2, 1, 3, 0 -> updates leave in order 0, 1, 2, 3 on 4 consecutive cycles.
- Allocate 4 branches; tag1 mispredicts -> tags 2 and 3 are squashed, count=2, next alloc_tag=2; a late resolution of tag 3 is ignored.
- Fill all 8 entries -> alloc_ready=0; retire 1 -> alloc_ready=1 next cycle; tail wraps to 0 correctly.
- Assert reset with 5 entries in flight -> count=0, all outputs 0, no pulses; then allocate -> alloc_tag=0.
